bp_me_io_dev_bridge: RTL and testbench

Single-outstanding bridge between the CCE-side uncached I/O memory channel and a simple 64-bit device register bus. It sits directly downstream of the I/O CCE:
- It accepts `e_cce_mem_uc_rd` / `e_cce_mem_uc_wr` messages on io_cmd.
- It converts each into one byte-masked, lane-aligned device access.
- It returns the matching io_resp message so the I/O CCE can issue `e_lce_cmd_uc_data` or `e_lce_cmd_uc_st_done`.

---
 rtl/bp_me_io_dev_bridge.sv | 236 +++++++++++++++++++++++
 tb/tb_bp_me_io_dev_bridge.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_io_dev_bridge.sv
// Single-outstanding bridge from the I/O CCE uncached memory channel to a 64-bit device register bus.
// Optional response watchdog with drain recovery: define BP_IO_DEV_BRIDGE_TIMEOUT_EN.

package bp_me_io_dev_bridge_pkg;

  typedef enum logic [1:0] {e_bp_default_cfg, e_bp_inv_cfg} bp_params_e;

  localparam int paddr_width_gp     = 40;
  localparam int cce_block_width_gp = 512;
  localparam int lce_id_width_gp    = 4;
  localparam int lce_assoc_gp       = 8;

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'b0000,
    e_cce_mem_wr    = 4'b0001,
    e_cce_mem_uc_rd = 4'b0010,
    e_cce_mem_uc_wr = 4'b0011
  } bp_cce_mem_cmd_type_e;

  typedef enum logic [2:0] {
    e_mem_msg_size_1  = 3'b000,
    e_mem_msg_size_2  = 3'b001,
    e_mem_msg_size_4  = 3'b010,
    e_mem_msg_size_8  = 3'b011,
    e_mem_msg_size_16 = 3'b100,
    e_mem_msg_size_32 = 3'b101,
    e_mem_msg_size_64 = 3'b110
  } bp_mem_msg_size_e;

  typedef struct packed {
    logic [$clog2(lce_assoc_gp)-1:0] way_id;
    logic [lce_id_width_gp-1:0]      lce_id;
  } bp_cce_mem_payload_s;

  typedef struct packed {
    bp_cce_mem_payload_s   payload;
    bp_mem_msg_size_e      size;
    logic [paddr_width_gp-1:0] addr;
    bp_cce_mem_cmd_type_e  msg_type;
  } bp_cce_mem_msg_header_s;

  typedef struct packed {
    logic [cce_block_width_gp-1:0] data;
    bp_cce_mem_msg_header_s        header;
  } bp_cce_mem_msg_s;

  localparam int cce_mem_msg_width_gp = $bits(bp_cce_mem_msg_s);

  // Sizes above one dword collapse onto the full 8-byte lane.
  function automatic logic [1:0] size_lg(input bp_mem_msg_size_e size);
    return (size > e_mem_msg_size_8) ? 2'd3 : size[1:0];
  endfunction

  function automatic logic [2:0] lane_off(input logic [2:0] a, input logic [1:0] lg);
    case (lg)
      2'd0:    return a;
      2'd1:    return {a[2:1], 1'b0};
      2'd2:    return {a[2], 2'b00};
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [7:0] byte_mask(input logic [1:0] lg);
    case (lg)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] data_mask(input logic [1:0] lg);
    logic [7:0] bm;
    bm = byte_mask(lg);
    for (int i = 0; i < 8; i++) data_mask[8*i +: 8] = {8{bm[i]}};
  endfunction

endpackage

module bp_me_io_dev_bridge
  import bp_me_io_dev_bridge_pkg::*;
#(
  parameter bp_params_e bp_params_p      = e_bp_inv_cfg,
  parameter int         timeout_cycles_p = 1024
) (
  input  logic                            clk_i,
  input  logic                            reset_i,

  input  logic [cce_mem_msg_width_gp-1:0] io_cmd_i,
  input  logic                            io_cmd_v_i,
  output logic                            io_cmd_ready_o,

  output logic [cce_mem_msg_width_gp-1:0] io_resp_o,
  output logic                            io_resp_v_o,
  input  logic                            io_resp_yumi_i,

  output logic                            dev_req_v_o,
  input  logic                            dev_req_ready_i,
  output logic                            dev_req_w_o,
  output logic [paddr_width_gp-1:0]       dev_req_addr_o,
  output logic [7:0]                      dev_req_mask_o,
  output logic [63:0]                     dev_req_data_o,

  input  logic                            dev_resp_v_i,
  input  logic [63:0]                     dev_resp_data_i,
  output logic                            dev_resp_ready_o
);

  if (timeout_cycles_p < 2 || bp_params_p != e_bp_inv_cfg) begin : g_bad_cfg
    $error("bp_me_io_dev_bridge: unsupported configuration");
  end

  typedef enum logic [1:0] {e_ready, e_send, e_wait, e_resp} state_e;

  state_e state_r, state_n;

  bp_cce_mem_msg_s        cmd;
  bp_cce_mem_msg_s        resp;
  bp_cce_mem_msg_header_s hdr_r;
  logic                   w_r;
  logic [paddr_width_gp-1:0] addr_r;
  logic [7:0]             mask_r;
  logic [63:0]            wdata_r;
  logic [63:0]            rdata_r;
  logic [2:0]             off_r;
  logic [1:0]             lg_r;

  logic [1:0]             cmd_lg;
  logic [2:0]             cmd_off;
  logic                   cmd_take;
  logic                   req_take;
  logic                   resp_take;
  logic                   timeout_hit;
  logic                   drain;

  logic unused_cmd_data;

  assign cmd             = io_cmd_i;
  assign unused_cmd_data = ^cmd.data[cce_block_width_gp-1:64];
  assign cmd_lg          = size_lg(cmd.header.size);
  assign cmd_off         = lane_off(cmd.header.addr[2:0], cmd_lg);

  assign cmd_take  = (state_r == e_ready) && io_cmd_v_i;
  assign req_take  = (state_r == e_send) && dev_req_ready_i;
  // A beat seen while draining belongs to an earlier, timed-out request.
  assign resp_take = (state_r == e_wait) && dev_resp_v_i && !drain;

`ifdef BP_IO_DEV_BRIDGE_TIMEOUT_EN
  localparam int cnt_width_lp = $clog2(timeout_cycles_p);

  logic [cnt_width_lp-1:0] cnt_r;
  logic                    drain_r;

  assign drain       = drain_r;
  assign timeout_hit = (state_r == e_wait) && !resp_take
                    && (cnt_r == cnt_width_lp'(timeout_cycles_p - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_r   <= '0;
      drain_r <= 1'b0;
    end else begin
      if (req_take)                 cnt_r <= '0;
      else if (state_r == e_wait)   cnt_r <= cnt_r + 1'b1;

      if (timeout_hit)              drain_r <= 1'b1;
      else if (drain_r && dev_resp_v_i) drain_r <= 1'b0;
    end
  end
`else
  assign drain       = 1'b0;
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_ready;
    else         state_r <= state_n;
  end

  // NOTE: next-state gets its default first so no path through the case infers a latch.
  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_ready: if (io_cmd_v_i)                state_n = e_send;
      e_send:  if (dev_req_ready_i)           state_n = e_wait;
      e_wait:  if (resp_take || timeout_hit)  state_n = e_resp;
      e_resp:  if (io_resp_yumi_i)            state_n = e_ready;
      default:                                state_n = e_ready;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hdr_r   <= '0;
      w_r     <= 1'b0;
      addr_r  <= '0;
      mask_r  <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
      off_r   <= '0;
      lg_r    <= '0;
    end else begin
      if (cmd_take) begin
        hdr_r   <= cmd.header;
        w_r     <= (cmd.header.msg_type == e_cce_mem_uc_wr);
        addr_r  <= {cmd.header.addr[paddr_width_gp-1:3], 3'b000};
        mask_r  <= byte_mask(cmd_lg) << cmd_off;
        wdata_r <= (cmd.data[63:0] & data_mask(cmd_lg)) << {cmd_off, 3'b000};
        off_r   <= cmd_off;
        lg_r    <= cmd_lg;
      end
      if (resp_take)
        rdata_r <= w_r ? '0 : ((dev_resp_data_i >> {off_r, 3'b000}) & data_mask(lg_r));
      else if (timeout_hit)
        rdata_r <= w_r ? '0 : data_mask(lg_r);
    end
  end

  always_comb begin
    resp        = '0;
    resp.header = hdr_r;
    resp.data   = {{(cce_block_width_gp-64){1'b0}}, rdata_r};
  end

  assign io_cmd_ready_o   = (state_r == e_ready);
  assign io_resp_v_o      = (state_r == e_resp);
  assign io_resp_o        = resp;
  assign dev_req_v_o      = (state_r == e_send);
  assign dev_req_w_o      = w_r;
  assign dev_req_addr_o   = addr_r;
  assign dev_req_mask_o   = mask_r;
  assign dev_req_data_o   = wdata_r;
  assign dev_resp_ready_o = (state_r == e_wait) || drain;

endmodule

// File: tb/tb_bp_me_io_dev_bridge.sv
// Directed self-checking bench for bp_me_io_dev_bridge; the watchdog scenario runs when
// BP_IO_DEV_BRIDGE_TIMEOUT_EN is defined.

module tb_bp_me_io_dev_bridge;
  import bp_me_io_dev_bridge_pkg::*;

  localparam int W = cce_mem_msg_width_gp;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [W-1:0] io_cmd_i;
  logic         io_cmd_v_i;
  logic         io_cmd_ready_o;
  logic [W-1:0] io_resp_o;
  logic         io_resp_v_o;
  logic         io_resp_yumi_i;
  logic         dev_req_v_o;
  logic         dev_req_ready_i;
  logic         dev_req_w_o;
  logic [paddr_width_gp-1:0] dev_req_addr_o;
  logic [7:0]   dev_req_mask_o;
  logic [63:0]  dev_req_data_o;
  logic         dev_resp_v_i;
  logic [63:0]  dev_resp_data_i;
  logic         dev_resp_ready_o;

  int n_cmp = 0;
  int n_err = 0;

  bp_me_io_dev_bridge #(.bp_params_p(e_bp_inv_cfg), .timeout_cycles_p(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .io_cmd_i(io_cmd_i), .io_cmd_v_i(io_cmd_v_i), .io_cmd_ready_o(io_cmd_ready_o),
    .io_resp_o(io_resp_o), .io_resp_v_o(io_resp_v_o), .io_resp_yumi_i(io_resp_yumi_i),
    .dev_req_v_o(dev_req_v_o), .dev_req_ready_i(dev_req_ready_i), .dev_req_w_o(dev_req_w_o),
    .dev_req_addr_o(dev_req_addr_o), .dev_req_mask_o(dev_req_mask_o), .dev_req_data_o(dev_req_data_o),
    .dev_resp_v_i(dev_resp_v_i), .dev_resp_data_i(dev_resp_data_i), .dev_resp_ready_o(dev_resp_ready_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_msg(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bp_cce_mem_msg_s make_msg(input bp_cce_mem_cmd_type_e t, input logic [39:0] a,
                                               input bp_mem_msg_size_e s, input logic [3:0] lce,
                                               input logic [63:0] d);
    bp_cce_mem_msg_s m;
    m = '0;
    m.header.msg_type       = t;
    m.header.addr           = a;
    m.header.size           = s;
    m.header.payload.lce_id = lce;
    m.header.payload.way_id = 3'd2;
    m.data[63:0]            = d;
    return m;
  endfunction

  // One full transaction with optional device-request and response back-pressure.
  task automatic run_txn(input string tag, input bp_cce_mem_msg_s cmd,
                         input logic [7:0] emask, input logic [39:0] eaddr, input logic [63:0] ewd,
                         input logic ew, input logic [63:0] ddata, input bp_cce_mem_msg_s eresp,
                         input int req_stall, input int yumi_stall);
    check({tag, " cmd_ready"}, 64'(io_cmd_ready_o), 64'(1));
    io_cmd_i   = cmd;
    io_cmd_v_i = 1'b1;
    tick();
    io_cmd_v_i = 1'b0;
    io_cmd_i   = '1;
    for (int i = 0; i <= req_stall; i++) begin
      check({tag, " req_v"},     64'(dev_req_v_o),    64'(1));
      check({tag, " req_addr"},  64'(dev_req_addr_o), 64'(eaddr));
      check({tag, " req_mask"},  64'(dev_req_mask_o), 64'(emask));
      check({tag, " req_data"},  dev_req_data_o,      ewd);
      check({tag, " req_w"},     64'(dev_req_w_o),    64'(ew));
      check({tag, " busy"},      64'(io_cmd_ready_o), 64'(0));
      dev_req_ready_i = (i == req_stall);
      tick();
    end
    dev_req_ready_i = 1'b0;
    check({tag, " req_v_drop"},  64'(dev_req_v_o),      64'(0));
    check({tag, " resp_ready"},  64'(dev_resp_ready_o), 64'(1));
    dev_resp_v_i    = 1'b1;
    dev_resp_data_i = ddata;
    tick();
    dev_resp_v_i    = 1'b0;
    dev_resp_data_i = 64'hA5A5_5A5A_C3C3_3C3C;
    for (int i = 0; i <= yumi_stall; i++) begin
      check({tag, " io_resp_v"},   64'(io_resp_v_o),    64'(1));
      check_msg({tag, " io_resp"}, io_resp_o,           eresp);
      check({tag, " busy2"},       64'(io_cmd_ready_o), 64'(0));
      io_resp_yumi_i = (i == yumi_stall);
      tick();
    end
    io_resp_yumi_i = 1'b0;
    check({tag, " resp_v_done"}, 64'(io_resp_v_o),    64'(0));
    check({tag, " ready_again"}, 64'(io_cmd_ready_o), 64'(1));
  endtask

  bp_cce_mem_msg_s c, r;

  initial begin
    reset_i = 1'b1;
    io_cmd_i = '0; io_cmd_v_i = 1'b0; io_resp_yumi_i = 1'b0;
    dev_req_ready_i = 1'b0; dev_resp_v_i = 1'b0; dev_resp_data_i = '0;
    tick();
    tick();
    check("rst req_v",      64'(dev_req_v_o),      64'(0));
    check("rst resp_v",     64'(io_resp_v_o),      64'(0));
    check("rst dresp_rdy",  64'(dev_resp_ready_o), 64'(0));
    check("rst req_mask",   64'(dev_req_mask_o),   64'(0));
    check_msg("rst io_resp", io_resp_o, '0);
    reset_i = 1'b0;
    check("rst cmd_ready",  64'(io_cmd_ready_o),   64'(1));

    // 8-byte read, minimum latency
    c = make_msg(e_cce_mem_uc_rd, 40'h00_0010_0008, e_mem_msg_size_8, 4'd5, 64'h0);
    r = c; r.data = '0; r.data[63:0] = 64'h1122_3344_5566_7788;
    run_txn("rd8", c, 8'hFF, 40'h00_0010_0008, 64'h0, 1'b0, 64'h1122_3344_5566_7788, r, 0, 0);

    // 1-byte write at lane 5; upper data bits must be masked off
    c = make_msg(e_cce_mem_uc_wr, 40'h00_0010_0105, e_mem_msg_size_1, 4'd3, 64'h0000_0000_0000_12AB);
    r = c; r.data = '0;
    run_txn("wr1", c, 8'h20, 40'h00_0010_0100, 64'h0000_AB00_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, r, 0, 0);

    // 2-byte read at offset 6, zero-extended
    c = make_msg(e_cce_mem_uc_rd, 40'h00_0010_0206, e_mem_msg_size_2, 4'd9, 64'h0);
    r = c; r.data = '0; r.data[63:0] = 64'h0000_0000_0000_BEEF;
    run_txn("rd2", c, 8'hC0, 40'h00_0010_0200, 64'h0, 1'b0, 64'hBEEF_1234_5678_9ABC, r, 0, 0);

    // Misaligned 4-byte read drops low bits to offset 0
    c = make_msg(e_cce_mem_uc_rd, 40'h00_0010_0303, e_mem_msg_size_4, 4'd1, 64'h0);
    r = c; r.data = '0; r.data[63:0] = 64'h0000_0000_3333_4444;
    run_txn("rd4", c, 8'h0F, 40'h00_0010_0300, 64'h0, 1'b0, 64'h1111_2222_3333_4444, r, 0, 0);

    // Oversized write is treated as 8 bytes
    c = make_msg(e_cce_mem_uc_wr, 40'h00_0010_0507, e_mem_msg_size_64, 4'd7, 64'h0123_4567_89AB_CDEF);
    r = c; r.data = '0;
    run_txn("wr64", c, 8'hFF, 40'h00_0010_0500, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0, r, 0, 0);

    // Back-pressure: device request stalled 5 cycles, response stalled 3 cycles
    c = make_msg(e_cce_mem_uc_rd, 40'h00_0010_0604, e_mem_msg_size_4, 4'd12, 64'h0);
    r = c; r.data = '0; r.data[63:0] = 64'h0000_0000_CAFE_F00D;
    run_txn("stall", c, 8'hF0, 40'h00_0010_0600, 64'h0, 1'b0, 64'hCAFE_F00D_0BAD_BEEF, r, 5, 3);

    // Reset while waiting on the device abandons the transaction
    c = make_msg(e_cce_mem_uc_rd, 40'h00_0010_0700, e_mem_msg_size_8, 4'd4, 64'h0);
    io_cmd_i = c; io_cmd_v_i = 1'b1;
    tick();
    io_cmd_v_i = 1'b0; dev_req_ready_i = 1'b1;
    tick();
    dev_req_ready_i = 1'b0;
    check("mid wait", 64'(dev_resp_ready_o), 64'(1));
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check("mrst cmd_ready",  64'(io_cmd_ready_o),   64'(1));
    check("mrst req_v",      64'(dev_req_v_o),      64'(0));
    check("mrst dresp_rdy",  64'(dev_resp_ready_o), 64'(0));
    check("mrst resp_v",     64'(io_resp_v_o),      64'(0));
    check("mrst req_addr",   64'(dev_req_addr_o),   64'(0));
    check_msg("mrst io_resp", io_resp_o, '0);
    c = make_msg(e_cce_mem_uc_rd, 40'h00_0010_0800, e_mem_msg_size_8, 4'd6, 64'h0);
    r = c; r.data = '0; r.data[63:0] = 64'h0F0E_0D0C_0B0A_0908;
    run_txn("post_rst", c, 8'hFF, 40'h00_0010_0800, 64'h0, 1'b0, 64'h0F0E_0D0C_0B0A_0908, r, 0, 0);

`ifdef BP_IO_DEV_BRIDGE_TIMEOUT_EN
    // Silent device: 8 wait cycles, then all-ones read data and one drained late beat
    c = make_msg(e_cce_mem_uc_rd, 40'h00_0010_0900, e_mem_msg_size_4, 4'd2, 64'h0);
    io_cmd_i = c; io_cmd_v_i = 1'b1;
    tick();
    io_cmd_v_i = 1'b0; dev_req_ready_i = 1'b1;
    tick();
    dev_req_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("to waiting", 64'(io_resp_v_o), 64'(0));
      tick();
    end
    r = c; r.data = '0; r.data[63:0] = 64'h0000_0000_FFFF_FFFF;
    check("to resp_v", 64'(io_resp_v_o), 64'(1));
    check_msg("to io_resp", io_resp_o, r);
    io_resp_yumi_i = 1'b1;
    tick();
    io_resp_yumi_i = 1'b0;
    check("to drain_rdy", 64'(dev_resp_ready_o), 64'(1));
    dev_resp_v_i = 1'b1; dev_resp_data_i = 64'h1234_5678_1234_5678;
    tick();
    dev_resp_v_i = 1'b0;
    check("to drained", 64'(dev_resp_ready_o), 64'(0));
    c = make_msg(e_cce_mem_uc_rd, 40'h00_0010_0A00, e_mem_msg_size_4, 4'd2, 64'h0);
    r = c; r.data = '0; r.data[63:0] = 64'h0000_0000_7654_3210;
    run_txn("after_to", c, 8'h0F, 40'h00_0010_0A00, 64'h0, 1'b0, 64'hFFFF_0000_7654_3210, r, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
